bist_decoder: RTL and testbench



---
 rtl/bist_decoder.sv | 72 +++++++
 tb/tb_bist_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bist_decoder.sv
// March-test data-background decoder: maps the 3-bit select q onto a WIDTH-bit background word.
// Define BIST_DECODER_COMB_EN for a purely combinational decode (clk/rst become unused).
module bist_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       q,
  output logic [WIDTH-1:0] data_t
);

  if (WIDTH < 2 || WIDTH > 64 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("bist_decoder: WIDTH must be even and within 2..64");
  end

  logic [WIDTH-1:0] chk_bg;
  logic [WIDTH-1:0] half_bg;
  logic [WIDTH-1:0] strp_bg;
  logic [WIDTH-1:0] dec;

  // Base (even-code) backgrounds; odd codes are their complements.
  always_comb begin
    chk_bg  = '0;
    half_bg = '0;
    strp_bg = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      chk_bg[i]  = i[0];
      half_bg[i] = (i >= WIDTH / 2);
      strp_bg[i] = i[1];
    end
  end

  // An unknown select matches no item and falls to the all-zero default.
  always_comb begin
    dec = '0;
    case (q)
      3'd0:    dec = chk_bg;
      3'd1:    dec = ~chk_bg;
      3'd2:    dec = half_bg;
      3'd3:    dec = ~half_bg;
      3'd4:    dec = '0;
      3'd5:    dec = '1;
      3'd6:    dec = strp_bg;
      3'd7:    dec = ~strp_bg;
      default: dec = '0;
    endcase
  end

`ifdef BIST_DECODER_COMB_EN
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};
  assign data_t         = dec;
`else
  logic [WIDTH-1:0] data_t_d;
  logic [WIDTH-1:0] data_t_q;

  always_comb begin
    data_t_d = dec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_t_q <= '0;
    end else begin
      data_t_q <= data_t_d;
    end
  end

  assign data_t = data_t_q;
`endif

endmodule

// File: tb/tb_bist_decoder.sv
// Self-checking bench for bist_decoder at WIDTH=8 and WIDTH=16 against a behavioural background model.
module tb_bist_decoder;

  logic        clk;
  logic        rst;
  logic [2:0]  q;
  logic [7:0]  data8;
  logic [15:0] data16;

  int n_tests = 0;
  int n_fail  = 0;

  bist_decoder #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .q      (q),
    .data_t (data8)
  );

  bist_decoder #(.WIDTH(16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .q      (q),
    .data_t (data16)
  );

  // Background defined bit by bit from the pattern rules.
  function automatic logic [63:0] ref_bg(input int w, input int code);
    logic [63:0] v;
    logic        b;
    v = '0;
    for (int i = 0; i < w; i++) begin
      case (code / 2)
        0:       b = (i % 2) == 1;
        1:       b = i >= (w / 2);
        2:       b = 1'b0;
        default: b = (i % 4) >= 2;
      endcase
      if ((code % 2) == 1) b = !b;
      v[i] = b;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

`ifdef BIST_DECODER_COMB_EN
  initial begin
    clk = 1'b0;
    rst = 1'b1;
    q   = 3'd0;
    #10;
    for (int c = 0; c < 8; c++) begin
      q = 3'(c);
      #1;
      check($sformatf("comb8_q%0d", c), 64'(data8), ref_bg(8, c));
      check($sformatf("comb16_q%0d", c), 64'(data16), ref_bg(16, c));
      rst = 1'b0;
      #1;
      check($sformatf("comb8_rst_q%0d", c), 64'(data8), ref_bg(8, c));
      rst = 1'b1;
      #8;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
`else
  logic [7:0]  exp8_tbl  [8] = '{8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h00, 8'hFF, 8'hCC, 8'h33};
  logic [15:0] exp16_tbl [8] = '{16'hAAAA, 16'h5555, 16'hFF00, 16'h00FF,
                                 16'h0000, 16'hFFFF, 16'hCCCC, 16'h3333};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    logic [63:0] prev8;
    logic [63:0] exp8;
    logic [63:0] exp16;
    int          c;
    bit          rst_cycle;

    rst = 1'b0;
    q   = 3'd5;
    #1;
    check("rst_async8", 64'(data8), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_hold8_%0d", k), 64'(data8), 64'h0);
      check($sformatf("rst_hold16_%0d", k), 64'(data16), 64'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_release8", 64'(data8), 64'hFF);
    check("rst_release16", 64'(data16), 64'hFFFF);

    // Sweep: value appears one edge after q, not before.
    prev8 = 64'hFF;
    for (int s = 0; s < 8; s++) begin
      q = 3'(s);
      #1;
      check($sformatf("latency8_q%0d", s), 64'(data8), prev8);
      @(negedge clk);
      check($sformatf("sweep8_q%0d", s), 64'(data8), 64'(exp8_tbl[s]));
      check($sformatf("sweep16_q%0d", s), 64'(data16), 64'(exp16_tbl[s]));
      prev8 = 64'(exp8_tbl[s]);
    end

    // Async reset between edges while q=2.
    q = 3'd2;
    @(posedge clk);
    #1;
    check("pre_async8", 64'(data8), 64'hF0);
    #1;
    rst = 1'b0;
    #1;
    check("mid_async8", 64'(data8), 64'h0);
    check("mid_async16", 64'(data16), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("still_zero8", 64'(data8), 64'h0);
    @(negedge clk);
    check("resume8", 64'(data8), 64'hF0);
    check("resume16", 64'(data16), 64'hFF00);

    // X/Z select decodes to zero where the simulator keeps the unknown.
    q = 3'bx1x;
    #1;
    exp8  = $isunknown(q) ? 64'h0 : ref_bg(8, int'(q));
    exp16 = $isunknown(q) ? 64'h0 : ref_bg(16, int'(q));
    @(negedge clk);
    check("xsel8", 64'(data8), exp8);
    check("xsel16", 64'(data16), exp16);

    // Random selects with occasional reset cycles.
    for (int n = 0; n < 300; n++) begin
      c         = int'($urandom_range(0, 7));
      rst_cycle = ($urandom_range(0, 15) == 0);
      q         = 3'(c);
      rst       = !rst_cycle;
      @(posedge clk);
      #1;
      exp8  = rst_cycle ? 64'h0 : ref_bg(8, c);
      exp16 = rst_cycle ? 64'h0 : ref_bg(16, c);
      check($sformatf("rand8_%0d_q%0d", n, c), 64'(data8), exp8);
      check($sformatf("rand16_%0d_q%0d", n, c), 64'(data16), exp16);
      @(negedge clk);
      rst = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
`endif

endmodule
